// File: rtl/eth_tx_sched.sv
// Two-requester TX frame-buffer scheduler: round-robin grant, commit/length check, send handshake.
// Optional send watchdog enabled by defining ETH_TX_SCHED_TIMEOUT_EN.
module eth_tx_sched #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MTU     = 1536,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       commit,
    // "release" is a reserved word, so the give-up pulse is named rel
    input  logic [1:0]       rel,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic             tx_start,
    output logic [LEN_W-1:0] tx_len,
    input  logic             tx_done,
    output logic             busy,
    output logic             err,
    output logic [15:0]      frames_sent
);

    typedef enum logic [1:0] {StIdle, StGrant, StSend, StWait} state_e;

    state_e           state;
    logic             last_win;
    logic             win;
    logic             owner;
    logic             commit_own;
    logic             rel_own;
    logic             req_own;
    logic [LEN_W-1:0] own_len;
    logic             len_ok;

    assign owner      = gnt[1];
    assign commit_own = commit[owner];
    assign rel_own    = rel[owner];
    assign req_own    = req[owner];
    assign own_len    = owner ? len1 : len0;
    assign len_ok     = (own_len != '0) && (32'(own_len) <= MTU);
    assign busy       = (state != StIdle);

    // With both requesting, the one that did not win last time goes next
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last_win;
        end
    end

`ifdef ETH_TX_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            gnt         <= 2'b00;
            tx_start    <= 1'b0;
            tx_len      <= '0;
            err         <= 1'b0;
            frames_sent <= 16'd0;
            last_win    <= 1'b1;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req != 2'b00) begin
                        state <= StGrant;
                        gnt   <= win ? 2'b10 : 2'b01;
                    end
                end
                StGrant: begin
                    // Commit takes priority over release or a falling req
                    if (commit_own) begin
                        if (len_ok) begin
                            tx_len <= own_len;
                            state  <= StSend;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (rel_own || !req_own) begin
                        state    <= StIdle;
                        gnt      <= 2'b00;
                        last_win <= owner;
                    end
                end
                StSend: begin
                    tx_start <= 1'b1;
                    state    <= StWait;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
                    wd_cnt   <= '0;
`endif
                end
                StWait: begin
                    if (tx_done) begin
                        state       <= StIdle;
                        gnt         <= 2'b00;
                        last_win    <= owner;
                        frames_sent <= frames_sent + 16'd1;
                    end
`ifdef ETH_TX_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        state    <= StIdle;
                        gnt      <= 2'b00;
                        last_win <= owner;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: begin
                    state <= StIdle;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule
